// File: rtl/spram_multiport_arb.sv
// Single-port synchronous RAM shared by NCH valid/ready channels, one access per clock.
// Define SPRAM_MULTIPORT_ARB_FIXED_SLOT_EN to replace round-robin with fixed TDM slots.
module spram_multiport_arb #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int NCH = 2,
  localparam int BW = DW / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_di,
  input  logic [NCH*BW-1:0] ch_be,
  output logic [NCH*DW-1:0] ch_do,
  output logic [NCH-1:0]    ch_rvalid
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshake: channel i transfers on a rising edge where ch_req[i] & ch_ready[i];
  // the request fields must stay stable until then, and ch_ready never rises without ch_req.
  logic [DW-1:0]  mem [2**AW];
  logic [NCH-1:0] gnt;
  logic [PW-1:0]  gnt_idx;
  logic           xfer;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_di;
  logic [BW-1:0]  sel_be;
  logic           rd_pend;
  logic [PW-1:0]  rd_ch;
  logic [AW-1:0]  rd_addr;

`ifdef SPRAM_MULTIPORT_ARB_FIXED_SLOT_EN
  logic [PW-1:0] slot;

  always_ff @(posedge clk) begin
    if (!rst) slot <= '0;
    else if (slot == PW'(NCH - 1)) slot <= '0;
    else slot <= slot + 1'b1;
  end

  // An unrequested slot stays idle; it is never handed to another channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = slot;
    for (int i = 0; i < NCH; i++) begin
      gnt[i] = (slot == PW'(i)) && ch_req[i];
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW:0]   rr_sum;
  logic [PW-1:0] rr_idx;
  logic          rr_found;

  // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two NCH works.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      rr_sum = {1'b0, ptr} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NCH)) rr_sum = rr_sum - (PW+1)'(NCH);
      rr_idx = rr_sum[PW-1:0];
      if (!rr_found && ch_req[rr_idx]) begin
        rr_found    = 1'b1;
        gnt[rr_idx] = 1'b1;
        gnt_idx     = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr <= '0;
    else if (xfer) ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  assign ch_ready = gnt & {NCH{rst}};
  assign xfer     = |ch_ready;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_di   = '0;
    sel_be   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_we   = ch_we[i];
        sel_addr = ch_addr[i*AW +: AW];
        sel_di   = ch_di[i*DW +: DW];
        sel_be   = ch_be[i*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && sel_we) begin
      for (int b = 0; b < BW; b++) begin
        if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_di[b*8 +: 8];
      end
    end
  end

  // Reads: address registered at acceptance, RAM data lands in the channel slice one edge later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend   <= 1'b0;
      rd_ch     <= '0;
      rd_addr   <= '0;
      ch_rvalid <= '0;
      ch_do     <= '0;
    end else begin
      rd_pend <= xfer && !sel_we;
      if (xfer) begin
        rd_ch   <= gnt_idx;
        rd_addr <= sel_addr;
      end
      ch_rvalid <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (rd_pend && (rd_ch == PW'(i))) begin
          ch_rvalid[i]       <= 1'b1;
          ch_do[i*DW +: DW]  <= mem[rd_addr];
        end
      end
    end
  end

endmodule
